// File: rtl/booth_pkg.sv
// Shared widths, Booth digit encoding and carry-save helpers for the
// booth_pp_compress front end.
package booth_pkg;

    localparam int OP_W    = 8;
    localparam int PROD_W  = 16;
    localparam int CARRY_W = 14;

    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } booth_digit_t;

    typedef logic [OP_W:0]      row_t;
    typedef logic [CARRY_W-1:0] vec_t;

    // Sum of the per-row -2^(8+2i) sign corrections, expressed from weight 2^2 upward
    localparam vec_t SIGN_CONST = 14'h2AC0;

    function automatic booth_digit_t decode_digit(input logic [2:0] bits);
        case (bits)
            3'b001, 3'b010: return POS1;
            3'b011:         return POS2;
            3'b100:         return NEG2;
            3'b101, 3'b110: return NEG1;
            default:        return ZERO;
        endcase
    endfunction

    function automatic vec_t csa_sum(input vec_t x, input vec_t y, input vec_t z);
        return x ^ y ^ z;
    endfunction

    function automatic vec_t csa_carry(input vec_t x, input vec_t y, input vec_t z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/booth_encoder.sv
// Radix-4 Booth row selector: picks 0, +-a or +-2a as a 9-bit one's-complement
// row plus a separate increment bit for negative digits.
module booth_encoder
    import booth_pkg::*;
(
    input  logic [2:0]      bits,
    input  logic [OP_W-1:0] a,
    output row_t            row,
    output logic            neg
);

    booth_digit_t digit;
    row_t         mag;

    always_comb begin
        digit = decode_digit(bits);
        mag   = '0;
        neg   = 1'b0;
        case (digit)
            POS1, NEG1: mag = {a[OP_W-1], a};
            POS2, NEG2: mag = {a, 1'b0};
            default:    mag = '0;
        endcase
        neg = (digit == NEG1) || (digit == NEG2);
        row = neg ? ~mag : mag;
    end

endmodule

// File: rtl/booth_pp_compress.sv
// Two-stage Booth multiplier front end: S1 registers the four Booth rows,
// S2 registers the carry-save {sum, carry} pair for the final adder.
module booth_pp_compress
    import booth_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    in_a,
    input  logic [OP_W-1:0]    in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PROD_W-1:0]  out_sum,
    output logic [CARRY_W-1:0] out_carry,
    output logic               busy
);

    logic [OP_W:0] b_ext;
    row_t          enc_row [4];
    logic [3:0]    enc_neg;

    row_t          s1_row [4];
    logic [3:0]    s1_neg;
    logic          s1_valid;
    logic          s2_valid;
    logic          s1_adv;
    logic          s2_adv;

    assign b_ext = {in_b, 1'b0};

    for (genvar i = 0; i < 4; i++) begin : g_enc
        booth_encoder u_enc (
            .bits (b_ext[2*i +: 3]),
            .a    (in_a),
            .row  (enc_row[i]),
            .neg  (enc_neg[i])
        );
    end

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;
    assign busy      = s1_valid || s2_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_neg   <= '0;
            s1_row   <= '{default: '0};
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_row <= enc_row;
                s1_neg <= enc_neg;
            end
        end
    end

    // Bits 0..1 come only from row 0 and neg0, so they are resolved with a
    // tiny adder; everything from weight 2^2 up goes through the 3:2 tree.
    logic [2:0] low;
    vec_t va, vb, vc, vd, ve;
    vec_t s1v, c1v, s2v, c2v, s3v, c3v;
    logic [PROD_W-1:0]  next_sum;
    logic [CARRY_W-1:0] next_carry;

    always_comb begin
        low = {1'b0, s1_row[0][1:0]} + {2'b00, s1_neg[0]};
        va  = vec_t'({~s1_row[0][8], s1_row[0][7:2]});
        vb  = vec_t'({~s1_row[1][8], s1_row[1][7:0]});
        vc  = vec_t'({~s1_row[2][8], s1_row[2][7:0]}) << 2;
        vd  = vec_t'({~s1_row[3][8], s1_row[3][7:0]}) << 4;
        ve  = SIGN_CONST | vec_t'({s1_neg[3], 1'b0, s1_neg[2], 1'b0, s1_neg[1]});

        s1v = csa_sum  (va, vb, vc);
        c1v = csa_carry(va, vb, vc);
        s2v = csa_sum  (vd, ve, c1v << 1);
        c2v = csa_carry(vd, ve, c1v << 1);
        s3v = csa_sum  (s1v, s2v, c2v << 1);
        c3v = csa_carry(s1v, s2v, c2v << 1);

        next_sum   = {s3v, low[1:0]};
        next_carry = CARRY_W'({c3v, low[2]});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            out_sum   <= '0;
            out_carry <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_sum   <= next_sum;
                out_carry <= next_carry;
            end
        end
    end

endmodule

// File: tb/tb_booth_pp_compress.sv
// Directed bench for booth_pp_compress: latency, extreme operands,
// backpressure hold/drain and asynchronous reset while full.
module tb_booth_pp_compress;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic [13:0] out_carry;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    booth_pp_compress dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .busy      (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
    endtask

    task automatic check_output(input string tag, input logic [15:0] product);
        logic [15:0] combined;
        combined = out_sum + {out_carry, 2'b00};
        check({tag, " valid"}, 16'(out_valid), 16'h0001);
        check({tag, " product"}, combined, product);
        check({tag, " low bits"}, 16'(out_sum[1:0]), 16'(product[1:0]));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;

        #2;
        check("reset out_valid", 16'(out_valid), 16'h0);
        check("reset busy", 16'(busy), 16'h0);
        check("reset out_sum", out_sum, 16'h0);
        check("reset out_carry", 16'(out_carry), 16'h0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        check("idle in_ready", 16'(in_ready), 16'h1);

        // Single operand: one registered stage in flight, then the result
        apply_stimulus(8'h03, 8'h05);
        step();
        in_valid = 1'b0;
        check("latency s1 out_valid", 16'(out_valid), 16'h0);
        check("latency s1 busy", 16'(busy), 16'h1);
        step();
        check_output("3x5", 16'h000F);
        step();
        check("3x5 drained out_valid", 16'(out_valid), 16'h0);
        check("3x5 drained busy", 16'(busy), 16'h0);

        // Back-to-back extremes at full throughput
        apply_stimulus(8'h80, 8'h80);
        step();
        apply_stimulus(8'h80, 8'h7F);
        step();
        check_output("-128x-128", 16'h4000);
        apply_stimulus(8'hFF, 8'hFF);
        step();
        check_output("-128x127", 16'hC080);
        in_valid = 1'b0;
        step();
        check_output("-1x-1", 16'h0001);
        step();
        check("stream end out_valid", 16'(out_valid), 16'h0);

        // Backpressure: both stages fill, outputs hold, then drain in order
        out_ready = 1'b0;
        apply_stimulus(8'h07, 8'h09);
        step();
        check("bp one entry in_ready", 16'(in_ready), 16'h1);
        apply_stimulus(8'hFB, 8'h06);
        step();
        check("bp full busy", 16'(busy), 16'h1);
        apply_stimulus(8'h64, 8'hFD);
        for (int i = 0; i < 5; i++) begin
            check_output("bp hold 7x9", 16'h003F);
            check("bp hold in_ready", 16'(in_ready), 16'h0);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", 16'(in_ready), 16'h1);
        step();
        in_valid = 1'b0;
        check_output("bp drain -5x6", 16'hFFE2);
        step();
        check_output("bp drain 100x-3", 16'hFED4);
        step();
        check("bp empty out_valid", 16'(out_valid), 16'h0);
        check("bp empty busy", 16'(busy), 16'h0);

        // Asynchronous reset while both stages hold entries
        out_ready = 1'b0;
        apply_stimulus(8'h0C, 8'h0C);
        step();
        apply_stimulus(8'hF9, 8'h03);
        step();
        in_valid = 1'b0;
        check_output("pre-reset 12x12", 16'h0090);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset out_valid", 16'(out_valid), 16'h0);
        check("async reset busy", 16'(busy), 16'h0);
        check("async reset out_sum", out_sum, 16'h0);
        check("async reset out_carry", 16'(out_carry), 16'h0);
        #3;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        step();
        check("post-reset out_valid", 16'(out_valid), 16'h0);
        check("post-reset busy", 16'(busy), 16'h0);

        apply_stimulus(8'h7F, 8'h7F);
        step();
        in_valid = 1'b0;
        step();
        check_output("127x127", 16'h3F01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
